// File: rtl/ads_spi_frame_rx.sv
// SPI master for the 4-channel ADS ADC: back-to-back frames, config words first, then AUTO_RST.
// Build option ADS_SPI_LOOPBACK_EN: MISO sampler takes the internal MOSI instead of the pin.
module ads_spi_frame_rx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned GAP_CYC    = 8,
  parameter logic [15:0] CFG_WORD0  = 16'h8500,
  parameter logic [15:0] CFG_WORD1  = 16'hA000,
  parameter logic [15:0] CFG_WORD2  = 16'h0B00,
  parameter logic [15:0] CFG_WORD3  = 16'h0D00,
  parameter logic [15:0] DATA_CMD   = 16'hA000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ads_miso,
  output logic        ads_cs,
  output logic        ads_sclk,
  output logic        ads_mosi,
  output logic [15:0] receive_data,
  output logic [15:0] pkg_num,
  output logic        busy
);

  localparam int unsigned M1      = (2 * CLK_DIV > SETUP_CYC) ? 2 * CLK_DIV : SETUP_CYC;
  localparam int unsigned M2      = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d, next_bit;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [15:0]        sr_q, sr_d;
  logic [15:0]        rd_q, rd_d;
  logic [15:0]        pkg_num_q, pkg_num_d;
  logic               busy_q, busy_d;
  logic [15:0]        word;
  logic               miso_src;

`ifdef ADS_SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = ads_miso;
  assign miso_src    = mosi_q;
`else
  assign miso_src    = ads_miso;
`endif

  always_comb begin
    case (pkg_num_q)
      16'd0:   word = CFG_WORD0;
      16'd1:   word = CFG_WORD1;
      16'd2:   word = CFG_WORD2;
      16'd3:   word = CFG_WORD3;
      default: word = DATA_CMD;
    endcase
  end

  assign next_bit = bit_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    sr_d      = sr_q;
    rd_d      = rd_q;
    pkg_num_d = pkg_num_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        pkg_num_d = '0;
        if (enable) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          mosi_d  = word[15];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          sclk_d = 1'b0;
          sr_d   = {sr_q[14:0], miso_src};
        end
        // End of one SCLK period: either launch the next bit or leave for HOLD.
        if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = next_bit;
            sclk_d = 1'b1;
            mosi_d = (next_bit < BIT_W'(16)) ? word[4'd15 - next_bit[3:0]] : 1'b0;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d   = GAP;
          cnt_d     = '0;
          cs_d      = 1'b1;
          rd_d      = sr_q;
          pkg_num_d = (pkg_num_q == '1) ? pkg_num_q : pkg_num_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (enable) begin
            state_d = SETUP;
            cs_d    = 1'b0;
          end else begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            pkg_num_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sr_q      <= '0;
      rd_q      <= '0;
      pkg_num_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      sr_q      <= sr_d;
      rd_q      <= rd_d;
      pkg_num_q <= pkg_num_d;
      busy_q    <= busy_d;
    end
  end

  assign ads_cs       = cs_q;
  assign ads_sclk     = sclk_q;
  assign ads_mosi     = mosi_q;
  assign receive_data = rd_q;
  assign pkg_num      = pkg_num_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ads_spi_frame_rx.sv
// Self-checking bench for ads_spi_frame_rx: ADC model on the SPI pins plus frame-level reference.
module tb_ads_spi_frame_rx;
  localparam int unsigned CD = 2;
  localparam int unsigned SU = 2;
  localparam int unsigned HO = 2;
  localparam int unsigned GP = 8;
`ifdef ADS_SPI_LOOPBACK_EN
  localparam int unsigned FB   = 16;
  localparam bit          LOOP = 1'b1;
`else
  localparam int unsigned FB   = 32;
  localparam bit          LOOP = 1'b0;
`endif
  localparam int unsigned FLEN = SU + 2 * CD * FB + HO;
  localparam int unsigned TMO  = 4 * (FLEN + GP) + 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ads_miso = 1'b0;
  logic        ads_cs, ads_sclk, ads_mosi, busy;
  logic [15:0] receive_data, pkg_num;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] exp_pkg;

  always #5 clk = ~clk;

  ads_spi_frame_rx #(
    .CLK_DIV(CD), .FRAME_BITS(FB), .SETUP_CYC(SU), .HOLD_CYC(HO), .GAP_CYC(GP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ads_miso(ads_miso),
    .ads_cs(ads_cs), .ads_sclk(ads_sclk), .ads_mosi(ads_mosi),
    .receive_data(receive_data), .pkg_num(pkg_num), .busy(busy)
  );

  // Reference: MOSI word chosen by frame number; expected receive_data per frame.
  function automatic logic [15:0] exp_word(input logic [15:0] n);
    case (n)
      16'd0:   return 16'h8500;
      16'd1:   return 16'hA000;
      16'd2:   return 16'h0B00;
      16'd3:   return 16'h0D00;
      default: return 16'hA000;
    endcase
  endfunction

  function automatic logic [15:0] exp_rd(input logic [15:0] w, input logic [15:0] adc);
    logic [63:0] s;
    s = '0;
    if (!LOOP) return adc;
    for (int k = 0; k < FB; k++) s[FB-1-k] = (k < 16) ? w[15-k] : 1'b0;
    return s[15:0];
  endfunction

  // ADC model and pin monitor.
  logic        cs_p = 1'b1, sclk_p = 1'b0;
  int unsigned lowcnt = 0, nbits = 0;
  logic [63:0] mbits = '0;
  logic [15:0] adc_cur = '0;
  logic [15:0] adc_q[$];
  int unsigned last_len = 0, last_bits = 0;
  logic [15:0] last_word = '0, last_adc = '0;

  always @(negedge clk) begin
    if (!ads_cs) begin
      if (cs_p) begin
        lowcnt = 0; nbits = 0; mbits = '0;
        adc_cur = (adc_q.size() != 0) ? adc_q.pop_front() : 16'($urandom);
      end
      lowcnt++;
      if (ads_sclk && !sclk_p) begin
        mbits = {mbits[62:0], ads_mosi};
        ads_miso = (nbits >= FB - 16) ? adc_cur[FB-1-nbits] : 1'($urandom);
        nbits++;
      end
    end else if (!cs_p && !rst) begin
      last_len  = lowcnt;
      last_bits = nbits;
      last_word = 16'(mbits >> (FB - 16));
      last_adc  = adc_cur;
    end
    cs_p   = ads_cs;
    sclk_p = ads_sclk;
  end

  task automatic wait_rise(output bit ok);
    logic p;
    p = ads_cs; ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (ads_cs === 1'b1 && p === 1'b0) begin ok = 1'b1; break; end
      p = ads_cs;
    end
    #1;
  endtask

  task automatic wait_fall(output bit ok);
    logic p;
    p = ads_cs; ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (ads_cs === 1'b0 && p === 1'b1) begin ok = 1'b1; break; end
      p = ads_cs;
    end
    #1;
  endtask

  task automatic wait_sclk(input int n, output bit ok);
    logic p;
    int c;
    p = ads_sclk; ok = 1'b0; c = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (ads_sclk === 1'b1 && p === 1'b0) c++;
      p = ads_sclk;
      if (c == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (ads_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", ads_cs); else n_pass++;
    n_chk++; if (ads_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", ads_sclk); else n_pass++;
    n_chk++; if (ads_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", ads_mosi); else n_pass++;
    n_chk++; if (receive_data !== 16'h0) $display("FAIL reset_rd got %h want 0", receive_data); else n_pass++;
    n_chk++; if (pkg_num !== 16'h0) $display("FAIL reset_pkg got %h want 0", pkg_num); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    exp_pkg = '0;
  endtask

  task automatic test_config_frames;
    bit ok;
    logic [15:0] w;
    adc_q.push_back(16'h1234); adc_q.push_back(16'h5678);
    adc_q.push_back(16'h9ABC); adc_q.push_back(16'hDEF0);
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    n_chk++; if (ads_cs !== 1'b0) $display("FAIL start_cs got %b want 0", ads_cs); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else n_pass++;
    for (int f = 0; f < 5; f++) begin
      wait_rise(ok);
      n_chk++; if (!ok) $display("FAIL cfg_timeout frame %0d got none want cs rise", f); else n_pass++;
      w = exp_word(exp_pkg);
      exp_pkg = (exp_pkg == 16'hFFFF) ? exp_pkg : exp_pkg + 16'd1;
      n_chk++; if (last_len != FLEN) $display("FAIL cfg_len frame %0d got %0d want %0d", f, last_len, FLEN); else n_pass++;
      n_chk++; if (last_bits != FB) $display("FAIL cfg_bits frame %0d got %0d want %0d", f, last_bits, FB); else n_pass++;
      n_chk++; if (last_word !== w) $display("FAIL cfg_word frame %0d got %h want %h", f, last_word, w); else n_pass++;
      n_chk++; if (pkg_num !== exp_pkg) $display("FAIL cfg_pkg frame %0d got %h want %h", f, pkg_num, exp_pkg); else n_pass++;
      n_chk++; if (receive_data !== exp_rd(w, last_adc)) $display("FAIL cfg_rd frame %0d got %h want %h", f, receive_data, exp_rd(w, last_adc)); else n_pass++;
    end
  endtask

  task automatic test_adc_stability;
    logic [15:0] hrd, hpkg, w;
    logic p;
    int cnt, changes;
    bit ok;
    hrd = receive_data; hpkg = pkg_num; p = ads_cs; cnt = 0; changes = 0; ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      cnt++;
      if (ads_cs === 1'b1 && p === 1'b0) begin ok = 1'b1; break; end
      p = ads_cs;
      if (receive_data !== hrd || pkg_num !== hpkg) changes++;
    end
    #1;
    n_chk++; if (!ok) $display("FAIL stab_timeout got none want cs rise"); else n_pass++;
    n_chk++; if (changes != 0) $display("FAIL stab_changes got %0d want 0", changes); else n_pass++;
    n_chk++; if (cnt != GP + FLEN) $display("FAIL stab_period got %0d want %0d", cnt, GP + FLEN); else n_pass++;
    w = exp_word(exp_pkg);
    exp_pkg = (exp_pkg == 16'hFFFF) ? exp_pkg : exp_pkg + 16'd1;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL stab_pkg got %h want %h", pkg_num, exp_pkg); else n_pass++;
    n_chk++; if (receive_data !== exp_rd(w, last_adc)) $display("FAIL stab_rd got %h want %h", receive_data, exp_rd(w, last_adc)); else n_pass++;
  endtask

  task automatic test_enable_drop;
    bit ok;
    logic [15:0] w;
    wait_fall(ok);
    n_chk++; if (!ok) $display("FAIL drop_fall got none want cs fall"); else n_pass++;
    wait_sclk(10, ok);
    enable = 1'b0;
    wait_rise(ok);
    n_chk++; if (!ok) $display("FAIL drop_rise got none want cs rise"); else n_pass++;
    w = exp_word(exp_pkg);
    exp_pkg = (exp_pkg == 16'hFFFF) ? exp_pkg : exp_pkg + 16'd1;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL drop_pkg got %h want %h", pkg_num, exp_pkg); else n_pass++;
    n_chk++; if (last_len != FLEN) $display("FAIL drop_len got %0d want %0d", last_len, FLEN); else n_pass++;
    n_chk++; if (receive_data !== exp_rd(w, last_adc)) $display("FAIL drop_rd got %h want %h", receive_data, exp_rd(w, last_adc)); else n_pass++;
    repeat (GP - 1) @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL drop_busy_gap got %b want 1", busy); else n_pass++;
    @(negedge clk);
    exp_pkg = '0;
    n_chk++; if (busy !== 1'b0) $display("FAIL drop_busy_idle got %b want 0", busy); else n_pass++;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL drop_pkg_clr got %h want %h", pkg_num, exp_pkg); else n_pass++;
    repeat (20) @(negedge clk);
    n_chk++; if (ads_cs !== 1'b1) $display("FAIL drop_idle_cs got %b want 1", ads_cs); else n_pass++;
    enable = 1'b1;
    wait_rise(ok);
    w = exp_word(exp_pkg);
    exp_pkg = exp_pkg + 16'd1;
    n_chk++; if (!ok || last_word !== w) $display("FAIL reen_word got %h want %h", last_word, w); else n_pass++;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL reen_pkg got %h want %h", pkg_num, exp_pkg); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    logic [15:0] w;
    wait_fall(ok);
    wait_sclk(20, ok);
    n_chk++; if (!ok) $display("FAIL rstm_sclk got none want 20 sclk rises"); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    exp_pkg = '0;
    n_chk++; if (ads_cs !== 1'b1) $display("FAIL rstm_cs got %b want 1", ads_cs); else n_pass++;
    n_chk++; if (ads_sclk !== 1'b0) $display("FAIL rstm_sclk got %b want 0", ads_sclk); else n_pass++;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL rstm_pkg got %h want %h", pkg_num, exp_pkg); else n_pass++;
    n_chk++; if (receive_data !== 16'h0) $display("FAIL rstm_rd got %h want 0", receive_data); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    wait_rise(ok);
    w = exp_word(exp_pkg);
    exp_pkg = exp_pkg + 16'd1;
    n_chk++; if (!ok || last_word !== w) $display("FAIL rstm_word got %h want %h", last_word, w); else n_pass++;
    n_chk++; if (pkg_num !== exp_pkg) $display("FAIL rstm_pkg_after got %h want %h", pkg_num, exp_pkg); else n_pass++;
    n_chk++; if (last_len != FLEN) $display("FAIL rstm_len got %0d want %0d", last_len, FLEN); else n_pass++;
  endtask

  task automatic test_saturation;
    bit ok;
    logic [15:0] w;
    wait_fall(ok);
    force dut.pkg_num_q = 16'hFFFE;
    @(negedge clk);
    release dut.pkg_num_q;
    exp_pkg = 16'hFFFE;
    for (int f = 0; f < 2; f++) begin
      wait_rise(ok);
      w = exp_word(exp_pkg);
      exp_pkg = (exp_pkg == 16'hFFFF) ? exp_pkg : exp_pkg + 16'd1;
      n_chk++; if (!ok || pkg_num !== exp_pkg) $display("FAIL sat_pkg frame %0d got %h want %h", f, pkg_num, exp_pkg); else n_pass++;
      n_chk++; if (last_word !== w) $display("FAIL sat_word frame %0d got %h want %h", f, last_word, w); else n_pass++;
      n_chk++; if (receive_data !== exp_rd(w, last_adc)) $display("FAIL sat_rd frame %0d got %h want %h", f, receive_data, exp_rd(w, last_adc)); else n_pass++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_config_frames;
    test_adc_stability;
    test_enable_drop;
    test_reset_mid_frame;
    test_saturation;
    repeat (GP + 4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
